// File: rtl/snowbro2_snd_pkg.sv
// Shared definitions for the Snow Bros 2 sound block: PCM fetch FSM states,
// default address width and the byte lane selector for 16-bit ROM words.
package snowbro2_snd_pkg;

    localparam int PCM_AW = 20;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        FILL,
        DONE
    } pcm_fsm_e;

    // Byte address bit 0 picks the lane: 0 -> low byte, 1 -> high byte.
    function automatic logic [7:0] pcm_byte_sel(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/snowbro2_pcm_cache_ram.sv
// Direct-mapped word cache storage for the PCM fetch: tag+data array with a
// valid vector that a single FLUSH cycle clears completely.
module snowbro2_pcm_cache_ram #(
    parameter int IDXW = 4,
    parameter int TW   = 15
) (
    input  logic            CLK96,
    input  logic            RESET96_N,
    input  logic            flush,
    input  logic [IDXW-1:0] rd_idx,
    output logic            rd_valid,
    output logic [TW-1:0]   rd_tag,
    output logic [15:0]     rd_data,
    input  logic            we,
    input  logic [IDXW-1:0] wr_idx,
    input  logic [TW-1:0]   wr_tag,
    input  logic [15:0]     wr_data
);

    localparam int DEPTH = 1 << IDXW;

    logic [TW+15:0]   mem [DEPTH];
    logic [DEPTH-1:0] valid;

    // NOTE: the array itself is never reset; the valid bits alone decide
    // whether an entry is usable, so the storage maps onto plain RAM.
    always_ff @(posedge CLK96) begin
        if (we)
            mem[wr_idx] <= {wr_tag, wr_data};
    end

    // A flush beats a write landing in the same cycle.
    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N)
            valid <= '0;
        else if (flush)
            valid <= '0;
        else if (we)
            valid[wr_idx] <= 1'b1;
    end

    assign rd_valid          = valid[rd_idx];
    assign {rd_tag, rd_data} = mem[rd_idx];

endmodule

// File: rtl/snowbro2_pcm_fetch.sv
// ADPCM byte fetch front end: turns PCM byte requests into 16-bit SDRAM word
// reads, with a small direct-mapped word cache in front of the SDRAM slot.
module snowbro2_pcm_fetch
    import snowbro2_snd_pkg::*;
#(
    parameter int AW   = PCM_AW,
    parameter int IDXW = 4
) (
    input  logic          CLK96,
    input  logic          RESET96_N,
    input  logic          PCM_CS,
    input  logic [AW-1:0] PCM_ADDR,
    output logic [7:0]    PCM_DOUT,
    output logic          PCM_OK,
    input  logic          FLUSH,
    output logic          SDR_CS,
    output logic [AW-2:0] SDR_ADDR,
    input  logic [15:0]   SDR_DATA,
    input  logic          SDR_OK,
    output logic          HIT
);

    localparam int TW = AW - 1 - IDXW;

    pcm_fsm_e        state, state_d;
    logic [AW-1:0]   addr_q;
    logic            cs_q;
    logic            abort_q, abort_d;
    logic            fflush_q, fflush_d;
    logic [7:0]      dout_d;
    logic            ok_d, sdr_cs_d, hit_d, cache_we;
    logic [AW-2:0]   sdr_addr_d;
    logic            new_req, abort_now, flush_now;

    logic            rd_valid;
    logic [TW-1:0]   rd_tag;
    logic [15:0]     rd_data;

    // Lookups always use the registered address, so PCM_DOUT is tied to it.
    wire [AW-2:0] waddr_q = addr_q[AW-1:1];

    snowbro2_pcm_cache_ram #(.IDXW(IDXW), .TW(TW)) u_cache (
        .CLK96     (CLK96),
        .RESET96_N (RESET96_N),
        .flush     (FLUSH),
        .rd_idx    (waddr_q[IDXW-1:0]),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .we        (cache_we),
        .wr_idx    (SDR_ADDR[IDXW-1:0]),
        .wr_tag    (SDR_ADDR[AW-2:IDXW]),
        .wr_data   (SDR_DATA)
    );

    assign new_req   = PCM_CS && (!cs_q || (PCM_ADDR != addr_q));
    assign abort_now = abort_q || new_req || !PCM_CS;
    assign flush_now = fflush_q || FLUSH;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d    = state;
        ok_d       = PCM_OK;
        dout_d     = PCM_DOUT;
        sdr_cs_d   = SDR_CS;
        sdr_addr_d = SDR_ADDR;
        hit_d      = 1'b0;
        abort_d    = abort_q;
        fflush_d   = fflush_q;
        cache_we   = 1'b0;

        case (state)
            IDLE: begin
                ok_d = 1'b0;
                if (new_req)
                    state_d = LOOKUP;
            end
            LOOKUP: begin
                if (!PCM_CS) begin
                    state_d = IDLE;
                end else if (!new_req) begin
                    if (rd_valid && (rd_tag == waddr_q[AW-2:IDXW]) && !FLUSH) begin
                        state_d = DONE;
                        dout_d  = pcm_byte_sel(rd_data, addr_q[0]);
                        ok_d    = 1'b1;
                        hit_d   = 1'b1;
                    end else begin
                        state_d    = FILL;
                        sdr_cs_d   = 1'b1;
                        sdr_addr_d = waddr_q;
                        abort_d    = 1'b0;
                        fflush_d   = 1'b0;
                    end
                end
            end
            FILL: begin
                // The SDRAM read cannot be withdrawn; remember why its data
                // must not reach PCM (request moved) or the cache (flushed).
                if (!SDR_OK) begin
                    abort_d  = abort_now;
                    fflush_d = flush_now;
                end else begin
                    cache_we = !flush_now;
                    sdr_cs_d = 1'b0;
                    if (abort_now) begin
                        state_d = PCM_CS ? LOOKUP : IDLE;
                    end else begin
                        state_d = DONE;
                        dout_d  = pcm_byte_sel(SDR_DATA, addr_q[0]);
                        ok_d    = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!PCM_CS) begin
                    state_d = IDLE;
                    ok_d    = 1'b0;
                end else if (new_req) begin
                    state_d = LOOKUP;
                    ok_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            state    <= IDLE;
            addr_q   <= '0;
            cs_q     <= 1'b0;
            abort_q  <= 1'b0;
            fflush_q <= 1'b0;
            PCM_DOUT <= '0;
            PCM_OK   <= 1'b0;
            SDR_CS   <= 1'b0;
            SDR_ADDR <= '0;
            HIT      <= 1'b0;
        end else begin
            state    <= state_d;
            addr_q   <= PCM_ADDR;
            cs_q     <= PCM_CS;
            abort_q  <= abort_d;
            fflush_q <= fflush_d;
            PCM_DOUT <= dout_d;
            PCM_OK   <= ok_d;
            SDR_CS   <= sdr_cs_d;
            SDR_ADDR <= sdr_addr_d;
            HIT      <= hit_d;
        end
    end

endmodule

// File: tb/tb_snowbro2_pcm_fetch.sv
// Directed bench for snowbro2_pcm_fetch: expected bytes are queued when a
// request is issued and popped when PCM_OK is observed.
module tb_snowbro2_pcm_fetch;

    localparam int AW = 20;

    logic          CLK96 = 1'b0;
    logic          RESET96_N;
    logic          PCM_CS;
    logic [AW-1:0] PCM_ADDR;
    logic [7:0]    PCM_DOUT;
    logic          PCM_OK;
    logic          FLUSH;
    logic          SDR_CS;
    logic [AW-2:0] SDR_ADDR;
    logic [15:0]   SDR_DATA;
    logic          SDR_OK;
    logic          HIT;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb [$];

    snowbro2_pcm_fetch #(.AW(AW), .IDXW(4)) dut (
        .CLK96     (CLK96),
        .RESET96_N (RESET96_N),
        .PCM_CS    (PCM_CS),
        .PCM_ADDR  (PCM_ADDR),
        .PCM_DOUT  (PCM_DOUT),
        .PCM_OK    (PCM_OK),
        .FLUSH     (FLUSH),
        .SDR_CS    (SDR_CS),
        .SDR_ADDR  (SDR_ADDR),
        .SDR_DATA  (SDR_DATA),
        .SDR_OK    (SDR_OK),
        .HIT       (HIT)
    );

    always #5 CLK96 = ~CLK96;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic logic [7:0] exp_byte(input logic [AW-1:0] a, input logic [15:0] d);
        return a[0] ? d[15:8] : d[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK96);
        #1;
    endtask

    task automatic expect_ok(input string tag);
        logic [7:0] e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_ok"}, PCM_OK, 1'b1);
            check({tag, "_dout"}, PCM_DOUT, e);
        end
    endtask

    // Miss: SDR_CS two edges after the request, data one edge after SDR_OK.
    task automatic do_miss(input logic [AW-1:0] a, input logic [15:0] d,
                           input int delay, input bit flush_at_ok);
        PCM_ADDR = a;
        PCM_CS   = 1'b1;
        sb.push_back(exp_byte(a, d));
        tick;
        check("miss_ok_low", PCM_OK, 1'b0);
        check("miss_lookup_no_cs", SDR_CS, 1'b0);
        tick;
        check("miss_cs", SDR_CS, 1'b1);
        check("miss_addr", SDR_ADDR, a[AW-1:1]);
        for (int i = 0; i < delay; i++) begin
            tick;
            check("fill_cs_hold", SDR_CS, 1'b1);
            check("fill_addr_hold", SDR_ADDR, a[AW-1:1]);
            check("fill_ok_low", PCM_OK, 1'b0);
        end
        SDR_DATA = d;
        SDR_OK   = 1'b1;
        FLUSH    = flush_at_ok;
        tick;
        SDR_OK = 1'b0;
        FLUSH  = 1'b0;
        expect_ok("miss_data");
        check("miss_cs_drop", SDR_CS, 1'b0);
        check("miss_no_hit", HIT, 1'b0);
    endtask

    // Hit: PCM_OK two edges after the change, one HIT pulse, no SDRAM access.
    task automatic do_hit(input logic [AW-1:0] a, input logic [7:0] e);
        PCM_ADDR = a;
        PCM_CS   = 1'b1;
        sb.push_back(e);
        tick;
        check("hit_ok_low", PCM_OK, 1'b0);
        check("hit_no_cs1", SDR_CS, 1'b0);
        tick;
        expect_ok("hit_data");
        check("hit_pulse", HIT, 1'b1);
        check("hit_no_cs2", SDR_CS, 1'b0);
        tick;
        check("hit_pulse_end", HIT, 1'b0);
        check("hit_ok_hold", PCM_OK, 1'b1);
    endtask

    initial begin
        RESET96_N = 1'b0;
        PCM_CS    = 1'b0;
        PCM_ADDR  = '0;
        FLUSH     = 1'b0;
        SDR_DATA  = '0;
        SDR_OK    = 1'b0;
        repeat (3) tick;
        check("rst_dout", PCM_DOUT, 8'h00);
        check("rst_ok", PCM_OK, 1'b0);
        check("rst_sdr_cs", SDR_CS, 1'b0);
        check("rst_sdr_addr", SDR_ADDR, '0);
        check("rst_hit", HIT, 1'b0);
        @(negedge CLK96);
        RESET96_N = 1'b1;
        tick;

        // First fetch misses, then the other byte of the same word hits.
        do_miss(20'h00010, 16'hBEEF, 5, 1'b0);
        do_hit(20'h00011, 8'hBE);

        // A stray SDR_OK outside FILL must not disturb the delivered byte.
        SDR_DATA = 16'h5555;
        SDR_OK   = 1'b1;
        tick;
        SDR_OK = 1'b0;
        tick;
        check("stray_ok_dout", PCM_DOUT, 8'hBE);
        check("stray_ok_ok", PCM_OK, 1'b1);
        check("stray_ok_cs", SDR_CS, 1'b0);

        // Same index, different tag: replacement in both directions.
        do_miss(20'h00030, 16'h1234, 3, 1'b0);
        do_miss(20'h00010, 16'hBEEF, 2, 1'b0);

        // Address moves while the 0x00050 fill is outstanding.
        PCM_ADDR = 20'h00050;
        tick;
        check("abort_ok_low", PCM_OK, 1'b0);
        tick;
        check("abort_fill_cs", SDR_CS, 1'b1);
        check("abort_fill_addr", SDR_ADDR, 19'h00028);
        tick;
        PCM_ADDR = 20'h00100;
        sb.push_back(exp_byte(20'h00100, 16'hC3D2));
        tick;
        tick;
        check("abort_ok_still_low", PCM_OK, 1'b0);
        check("abort_cs_held", SDR_CS, 1'b1);
        check("abort_addr_held", SDR_ADDR, 19'h00028);
        SDR_DATA = 16'h5A5A;
        SDR_OK   = 1'b1;
        tick;
        SDR_OK = 1'b0;
        check("abort_done_ok_low", PCM_OK, 1'b0);
        check("abort_done_cs_low", SDR_CS, 1'b0);
        tick;
        check("refill_cs", SDR_CS, 1'b1);
        check("refill_addr", SDR_ADDR, 19'h00080);
        tick;
        SDR_DATA = 16'hC3D2;
        SDR_OK   = 1'b1;
        tick;
        SDR_OK = 1'b0;
        expect_ok("refill_data");
        do_hit(20'h00050, 8'h5A);

        // FLUSH after caching 0x00010 forces the next request to miss.
        do_miss(20'h00010, 16'hBEEF, 1, 1'b0);
        FLUSH = 1'b1;
        tick;
        FLUSH  = 1'b0;
        PCM_CS = 1'b0;
        tick;
        do_miss(20'h00010, 16'hBEEF, 1, 1'b0);

        // FLUSH coinciding with SDR_OK: data delivered, not cached.
        PCM_CS = 1'b0;
        tick;
        FLUSH = 1'b1;
        tick;
        FLUSH = 1'b0;
        do_miss(20'h00010, 16'hA1B2, 2, 1'b1);
        PCM_CS = 1'b0;
        tick;
        do_miss(20'h00010, 16'hA1B2, 0, 1'b0);

        // Reset in the middle of a fill, then a late SDR_OK.
        PCM_CS = 1'b0;
        tick;
        PCM_ADDR = 20'h00020;
        PCM_CS   = 1'b1;
        tick;
        tick;
        check("rstfill_cs", SDR_CS, 1'b1);
        #2;
        RESET96_N = 1'b0;
        PCM_CS    = 1'b0;
        #1;
        check("rstfill_cs_async", SDR_CS, 1'b0);
        check("rstfill_ok_async", PCM_OK, 1'b0);
        repeat (2) tick;
        @(negedge CLK96);
        RESET96_N = 1'b1;
        tick;
        SDR_DATA = 16'h7777;
        SDR_OK   = 1'b1;
        tick;
        SDR_OK = 1'b0;
        check("late_ok_ignored", PCM_OK, 1'b0);
        check("late_ok_cs", SDR_CS, 1'b0);
        tick;
        check("late_ok_ignored2", PCM_OK, 1'b0);
        do_miss(20'h00010, 16'hBEEF, 1, 1'b0);

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
